// File: rtl/bubble_page_buffer_pkg.sv
// Shared types and defaults for the bubble page buffer.
// No logic; constants only.
// No flow control at this level.
package bubble_page_buffer_pkg;

  // Lifecycle of one page bank.
  typedef enum logic [1:0] {
    BANK_EMPTY    = 2'd0,
    BANK_FILLING  = 2'd1,
    BANK_FULL     = 2'd2,
    BANK_DRAINING = 2'd3
  } bank_status_e;

  localparam int unsigned PAGE_WORDS_DEFAULT = 1168;
  localparam int unsigned ADDR_W_DEFAULT     = 11;
  localparam logic        IDLE_LEVEL_DEFAULT = 1'b1;

endpackage

// File: rtl/bubble_page_buffer_ram.sv
// Two-bank page store: one write port, one synchronous read port.
// Read data valid one cycle after the read address is presented.
// No backpressure; the write is accepted every cycle wr_en_i is high.
module bubble_page_ram #(
  parameter int unsigned ADDR_W = 11
) (
  input  logic              clk_i,
  input  logic              wr_en_i,
  input  logic [ADDR_W:0]   wr_addr_i,
  input  logic [1:0]        wr_data_i,
  input  logic [ADDR_W:0]   rd_addr_i,
  output logic [1:0]        rd_data_o
);

  localparam int unsigned DEPTH = 2 ** (ADDR_W + 1);

  logic [1:0] mem_q [DEPTH];
  logic [1:0] rd_data_q;

  // Write port and registered read port, no reset so it maps onto block RAM.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
    rd_data_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/bubble_page_buffer.sv
// Ping-pong page buffer between the flash page loader and the bubble output.
// Drain latency: a word reaches the outputs 2 cycles after rd_start/strobe.
// No stalling: misuse is dropped and reported through sticky underrun/overrun.
module bubble_page_buffer
  import bubble_page_buffer_pkg::*;
#(
  parameter int unsigned PAGE_WORDS = PAGE_WORDS_DEFAULT,
  parameter int unsigned ADDR_W     = ADDR_W_DEFAULT,
  parameter logic        IDLE_LEVEL = IDLE_LEVEL_DEFAULT
) (
  input  logic              master_clock,
  input  logic              nreset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [1:0]        wr_data,
  input  logic              load_done,
  output logic              load_request,
  input  logic              rd_start,
  input  logic              data_out_strobe,
  output logic              bubble_out_odd,
  output logic              bubble_out_even,
  output logic              page_ready,
  output logic              draining,
  output logic              underrun,
  output logic              overrun,
  input  logic              clear_flags
);

  localparam logic [ADDR_W:0]   PAGE_WORDS_X = (ADDR_W + 1)'(PAGE_WORDS);
  localparam logic [ADDR_W-1:0] LAST_ADDR    = ADDR_W'(PAGE_WORDS - 1);
  localparam logic [1:0]        IDLE_PAIR    = {IDLE_LEVEL, IDLE_LEVEL};

  bank_status_e      status_q [2];
  bank_status_e      status_d [2];
  logic              fill_sel_q, fill_sel_d;
  logic              drain_sel_q, drain_sel_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              draining_q, draining_d;
  logic              underrun_q, underrun_d;
  logic              overrun_q, overrun_d;
  logic              load_request_q;
  logic              page_ready_q;
  logic              rd_vld_q;
  logic [1:0]        out_q;

  logic              fill_open;
  logic              addr_ok;
  logic              wr_fire;
  logic [1:0]        ram_rd_data;

  // The fill bank accepts data only until it has been handed to the drain side.
  assign fill_open = (status_q[fill_sel_q] == BANK_EMPTY) ||
                     (status_q[fill_sel_q] == BANK_FILLING);
  assign addr_ok   = ({1'b0, wr_addr} < PAGE_WORDS_X);

  // Bank bookkeeping: fill side and drain side act on their own bank each cycle.
  always_comb begin
    status_d    = status_q;
    fill_sel_d  = fill_sel_q;
    drain_sel_d = drain_sel_q;
    rd_addr_d   = rd_addr_q;
    draining_d  = draining_q;
    underrun_d  = underrun_q;
    overrun_d   = overrun_q;
    wr_fire     = 1'b0;

    // Clear first so that a flag set in the same cycle still sticks.
    if (clear_flags) begin
      underrun_d = 1'b0;
      overrun_d  = 1'b0;
    end

    // A write lands before a same-cycle load_done marks the bank FULL.
    if (wr_en) begin
      if (fill_open && addr_ok) begin
        wr_fire                = 1'b1;
        status_d[fill_sel_q]   = BANK_FILLING;
      end else begin
        overrun_d = 1'b1;
      end
    end

    if (load_done) begin
      if (fill_open) begin
        status_d[fill_sel_q] = BANK_FULL;
        fill_sel_d           = ~fill_sel_q;
      end else begin
        overrun_d = 1'b1;
      end
    end

    // A page can only start from a FULL bank and never on top of a running one.
    if (rd_start) begin
      if (draining_q || (status_q[drain_sel_q] != BANK_FULL)) begin
        underrun_d = 1'b1;
      end else begin
        status_d[drain_sel_q] = BANK_DRAINING;
        rd_addr_d             = '0;
        draining_d            = 1'b1;
      end
    end

    if (data_out_strobe && draining_q) begin
      if (rd_addr_q == LAST_ADDR) begin
        status_d[drain_sel_q] = BANK_EMPTY;
        drain_sel_d           = ~drain_sel_q;
        draining_d            = 1'b0;
        rd_addr_d             = '0;
      end else begin
        rd_addr_d = rd_addr_q + ADDR_W'(1);
      end
    end
  end

  // Control state and status outputs, all cleared by reset.
  always_ff @(posedge master_clock or negedge nreset) begin
    if (!nreset) begin
      status_q[0]    <= BANK_EMPTY;
      status_q[1]    <= BANK_EMPTY;
      fill_sel_q     <= 1'b0;
      drain_sel_q    <= 1'b0;
      rd_addr_q      <= '0;
      draining_q     <= 1'b0;
      underrun_q     <= 1'b0;
      overrun_q      <= 1'b0;
      load_request_q <= 1'b1;
      page_ready_q   <= 1'b0;
    end else begin
      status_q       <= status_d;
      fill_sel_q     <= fill_sel_d;
      drain_sel_q    <= drain_sel_d;
      rd_addr_q      <= rd_addr_d;
      draining_q     <= draining_d;
      underrun_q     <= underrun_d;
      overrun_q      <= overrun_d;
      load_request_q <= (status_d[fill_sel_d] == BANK_EMPTY);
      page_ready_q   <= (status_d[drain_sel_d] == BANK_FULL);
    end
  end

  // Output pipeline: the valid bit tracks the RAM read stage, then the word
  // (or the idle level once the page has ended) is registered onto the pins.
  always_ff @(posedge master_clock or negedge nreset) begin
    if (!nreset) begin
      rd_vld_q <= 1'b0;
      out_q    <= IDLE_PAIR;
    end else begin
      rd_vld_q <= draining_q;
      out_q    <= rd_vld_q ? ram_rd_data : IDLE_PAIR;
    end
  end

  bubble_page_ram #(
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk_i     (master_clock),
    .wr_en_i   (wr_fire),
    .wr_addr_i ({fill_sel_q, wr_addr}),
    .wr_data_i (wr_data),
    .rd_addr_i ({drain_sel_q, rd_addr_q}),
    .rd_data_o (ram_rd_data)
  );

  assign load_request    = load_request_q;
  assign page_ready      = page_ready_q;
  assign draining        = draining_q;
  assign underrun        = underrun_q;
  assign overrun         = overrun_q;
  assign bubble_out_odd  = out_q[1];
  assign bubble_out_even = out_q[0];

endmodule

// File: tb/tb_bubble_page_buffer.sv
// Directed bench for bubble_page_buffer with an 8-word page.
// Inputs change 1 ns after a rising edge; outputs are sampled there too.
// Words are packed 2 bits each into 16-bit patterns, word 0 in bits [1:0].
module tb_bubble_page_buffer;

  logic       clk = 1'b0;
  logic       nreset;
  logic       wr_en, load_done, rd_start, data_out_strobe, clear_flags;
  logic [3:0] wr_addr;
  logic [1:0] wr_data;
  logic       load_request, bubble_out_odd, bubble_out_even;
  logic       page_ready, draining, underrun, overrun;

  int errors = 0;
  int checks = 0;

  // background filler used while a page drains
  bit         bg_on = 1'b0;
  int         bg_idx = 0;
  logic [15:0] bg_dat = '0;

  always #5 clk = ~clk;

  bubble_page_buffer #(
    .PAGE_WORDS (8),
    .ADDR_W     (4),
    .IDLE_LEVEL (1'b1)
  ) dut (
    .master_clock    (clk),
    .nreset          (nreset),
    .wr_en           (wr_en),
    .wr_addr         (wr_addr),
    .wr_data         (wr_data),
    .load_done       (load_done),
    .load_request    (load_request),
    .rd_start        (rd_start),
    .data_out_strobe (data_out_strobe),
    .bubble_out_odd  (bubble_out_odd),
    .bubble_out_even (bubble_out_even),
    .page_ready      (page_ready),
    .draining        (draining),
    .underrun        (underrun),
    .overrun         (overrun),
    .clear_flags     (clear_flags)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    if (bg_on && bg_idx < 8) begin
      wr_en   = 1'b1;
      wr_addr = 4'(bg_idx);
      wr_data = bg_dat[2*bg_idx +: 2];
      bg_idx++;
    end
    @(posedge clk);
    #1;
    if (bg_on) wr_en = 1'b0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [1:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    cyc();
    wr_en = 1'b0;
  endtask

  task automatic pulse_load_done();
    load_done = 1'b1;
    cyc();
    load_done = 1'b0;
  endtask

  task automatic pulse_clear();
    clear_flags = 1'b1;
    cyc();
    clear_flags = 1'b0;
  endtask

  task automatic fill(input logic [15:0] p);
    for (int i = 0; i < 8; i++) wr(4'(i), p[2*i +: 2]);
    pulse_load_done();
  endtask

  function automatic logic [15:0] outs();
    return {14'd0, bubble_out_odd, bubble_out_even};
  endfunction

  // Start a page and check every word, its 2-cycle latency and the idle tail.
  task automatic drain(input logic [15:0] exp, input int stop_at,
                       input bit ld_last, input int dup_at);
    rd_start = 1'b1;
    cyc();
    rd_start = 1'b0;
    chk("drn_active", 16'(draining), 16'd1);
    chk("drn_pg_rdy_low", 16'(page_ready), 16'd0);
    cyc();
    chk("lat_w0_early", outs(), 16'd3);
    cyc();
    chk("word0", outs(), 16'(exp[1:0]));
    for (int k = 1; k < 8; k++) begin
      data_out_strobe = 1'b1;
      cyc();
      data_out_strobe = 1'b0;
      cyc();
      chk("word_hold", outs(), 16'(exp[2*(k-1) +: 2]));
      cyc();
      chk("word_k", outs(), 16'(exp[2*k +: 2]));
      if (k == dup_at) begin
        rd_start = 1'b1;
        cyc();
        rd_start = 1'b0;
        chk("dup_start_underrun", 16'(underrun), 16'd1);
        chk("dup_start_still_drn", 16'(draining), 16'd1);
      end
      if (k == stop_at) return;
    end
    data_out_strobe = 1'b1;
    load_done = ld_last;
    cyc();
    data_out_strobe = 1'b0;
    load_done = 1'b0;
    chk("end_draining", 16'(draining), 16'd0);
    chk("end_hold1", outs(), 16'(exp[15:14]));
    cyc();
    chk("end_hold2", outs(), 16'(exp[15:14]));
    cyc();
    chk("end_idle", outs(), 16'd3);
  endtask

  initial begin
    nreset = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; load_done = 1'b0;
    rd_start = 1'b0; data_out_strobe = 1'b0; clear_flags = 1'b0;
    repeat (2) cyc();

    // reset state
    chk("rst_load_request", 16'(load_request), 16'd1);
    chk("rst_page_ready", 16'(page_ready), 16'd0);
    chk("rst_draining", 16'(draining), 16'd0);
    chk("rst_underrun", 16'(underrun), 16'd0);
    chk("rst_overrun", 16'(overrun), 16'd0);
    chk("rst_outs", outs(), 16'd3);
    nreset = 1'b1;
    cyc();

    // fill bank 0 with 0,1,2,3,0,1,2,3
    for (int i = 0; i < 8; i++) wr(4'(i), 2'(i % 4));
    chk("filling_no_request", 16'(load_request), 16'd0);
    pulse_load_done();
    chk("bank1_request", 16'(load_request), 16'd1);
    chk("bank0_ready", 16'(page_ready), 16'd1);
    chk("fill_no_overrun", 16'(overrun), 16'd0);

    // drain bank 0 while bank 1 fills; load_done coincides with last strobe
    bg_dat = 16'h1B1B; bg_idx = 0; bg_on = 1'b1;
    drain(16'hE4E4, 8, 1'b1, -1);
    bg_on = 1'b0;
    chk("pp_page_ready", 16'(page_ready), 16'd1);
    chk("pp_load_request", 16'(load_request), 16'd1);
    chk("pp_overrun", 16'(overrun), 16'd0);

    // drain bank 1, filled in the background
    drain(16'h1B1B, 8, 1'b0, -1);
    chk("both_empty_ready", 16'(page_ready), 16'd0);

    // underrun with both banks empty
    rd_start = 1'b1;
    cyc();
    rd_start = 1'b0;
    chk("ur_flag", 16'(underrun), 16'd1);
    cyc(); cyc();
    chk("ur_not_draining", 16'(draining), 16'd0);
    chk("ur_outs_idle", outs(), 16'd3);
    pulse_clear();
    chk("ur_cleared", 16'(underrun), 16'd0);
    rd_start = 1'b1; clear_flags = 1'b1;
    cyc();
    rd_start = 1'b0; clear_flags = 1'b0;
    chk("ur_set_wins", 16'(underrun), 16'd1);
    pulse_clear();

    // fill both banks, then a write must be dropped as overrun
    fill(16'h0FA5);
    fill(16'h55AA);
    chk("full_no_request", 16'(load_request), 16'd0);
    wr(4'd0, 2'b10);
    chk("ovr_write", 16'(overrun), 16'd1);
    pulse_clear();
    pulse_load_done();
    chk("ovr_load_done", 16'(overrun), 16'd1);
    drain(16'h0FA5, 8, 1'b0, 3);
    drain(16'h55AA, 8, 1'b0, -1);

    // reset in the middle of a page
    fill(16'hE4E4);
    drain(16'hE4E4, 4, 1'b0, -1);
    nreset = 1'b0;
    #1;
    chk("mid_rst_load_request", 16'(load_request), 16'd1);
    chk("mid_rst_page_ready", 16'(page_ready), 16'd0);
    chk("mid_rst_draining", 16'(draining), 16'd0);
    chk("mid_rst_underrun", 16'(underrun), 16'd0);
    chk("mid_rst_overrun", 16'(overrun), 16'd0);
    chk("mid_rst_outs", outs(), 16'd3);
    cyc(); cyc();
    nreset = 1'b1;
    cyc();
    fill(16'h1B1B);
    drain(16'h1B1B, 8, 1'b0, -1);

    // out-of-page address: dropped, flags overrun, bank stays EMPTY
    wr(4'd8, 2'b10);
    chk("addr8_overrun", 16'(overrun), 16'd1);
    cyc();
    chk("addr8_bank_empty", 16'(load_request), 16'd1);
    pulse_clear();

    // load_done on an EMPTY bank still makes it FULL
    pulse_load_done();
    chk("empty_ld_ready", 16'(page_ready), 16'd1);
    chk("empty_ld_overrun", 16'(overrun), 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
